// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: runtime baud divisor, 3-sample majority vote,
// optional parity, framing/break flags, and a FWFT output FIFO with overrun.
module uart_rx_os #(
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1,
    parameter int OVERSAMPLE   = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int DIV_W        = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          uart_rxd,
    input  logic                          uart_rx_en,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic [1:0]                    parity_mode,
    output logic [PAYLOAD_BITS-1:0]       rx_data,
    output logic [2:0]                    rx_flags,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          rx_overrun,
    input  logic                          overrun_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BC_W  = $clog2(PAYLOAD_BITS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [OS_W-1:0] V0      = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] V1      = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0] VP      = OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, PUSH} state_t;

    typedef struct packed {
        logic                    brk;
        logic                    par_err;
        logic                    frm_err;
        logic [PAYLOAD_BITS-1:0] data;
    } entry_t;

    state_t                  state;
    logic                    sync1, sync2;
    logic [DIV_W-1:0]        div_q, div_cnt;
    logic                    tick, start_det, at_mid, at_end, vote;
    logic [OS_W-1:0]         os_cnt;
    logic [BC_W-1:0]         bit_cnt;
    logic                    v0, v1;
    logic [PAYLOAD_BITS-1:0] shreg;
    logic                    par_en, par_odd, par_bit, frame_err;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else if (!uart_rx_en) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= uart_rxd;
            sync2 <= sync1;
        end
    end

    // >= rather than == so a divisor lowered while idle cannot strand the counter
    assign tick      = (div_cnt >= div_q);
    assign start_det = (state == IDLE) && tick && !sync2;
    assign at_mid    = tick && (os_cnt == VP);
    assign at_end    = tick && (os_cnt == OS_LAST);
    assign vote      = (v0 & v1) | (v0 & sync2) | (v1 & sync2);

    // start_det is always a tick, so the wrap also realigns the frame phase
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_q   <= '0;
            div_cnt <= '0;
        end else begin
            if (state == IDLE) div_q <= baud_div;
            if (tick) div_cnt <= '0;
            else      div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            os_cnt    <= '0;
            bit_cnt   <= '0;
            v0        <= 1'b1;
            v1        <= 1'b1;
            shreg     <= '0;
            par_en    <= 1'b0;
            par_odd   <= 1'b0;
            par_bit   <= 1'b0;
            frame_err <= 1'b0;
        end else if (!uart_rx_en) begin
            state <= IDLE;
        end else begin
            if (tick && state != IDLE) begin
                os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
                if (os_cnt == V0) v0 <= sync2;
                if (os_cnt == V1) v1 <= sync2;
            end
            case (state)
                IDLE: if (start_det) begin
                    state     <= START;
                    os_cnt    <= '0;
                    bit_cnt   <= '0;
                    par_bit   <= 1'b0;
                    frame_err <= 1'b0;
                    par_en    <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                    par_odd   <= (parity_mode == 2'b10);
                end
                START: begin
                    if (at_mid && vote) state <= IDLE;
                    else if (at_end)    state <= DATA;
                end
                DATA: begin
                    if (at_mid) shreg <= {vote, shreg[PAYLOAD_BITS-1:1]};
                    if (at_end) begin
                        if (bit_cnt == BC_W'(PAYLOAD_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= par_en ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (at_mid) par_bit <= vote;
                    if (at_end) state <= STOP;
                end
                // leave on the final stop vote so a back-to-back start edge is not missed
                STOP: begin
                    if (at_mid) begin
                        if (!vote) frame_err <= 1'b1;
                        if (bit_cnt == BC_W'(STOP_BITS - 1)) state <= PUSH;
                    end
                    if (at_end) bit_cnt <= bit_cnt + 1'b1;
                end
                PUSH:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    entry_t              push_entry, head;
    entry_t              mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [LVL_W-1:0]    level;
    logic                push, pop, full, wr_ok;

    assign push_entry.data    = shreg;
    assign push_entry.par_err = par_en & (^shreg ^ par_bit ^ par_odd);
    assign push_entry.frm_err = frame_err;
    assign push_entry.brk     = (shreg == '0) & ~(par_en & par_bit) & frame_err;

    assign push  = (state == PUSH);
    assign pop   = rx_valid & rx_ready;
    assign full  = (level == LVL_W'(FIFO_DEPTH));
    assign wr_ok = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            rx_overrun <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (push && full && !pop) rx_overrun <= 1'b1;
            else if (overrun_clr)     rx_overrun <= 1'b0;
        end
    end

    assign rx_valid   = (level != '0);
    assign head       = rx_valid ? mem[rd_ptr] : '0;
    assign rx_data    = head.data;
    assign rx_flags   = {head.brk, head.par_err, head.frm_err};
    assign fifo_level = level;
endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: directed scenarios plus random frames,
// scored against a frame-level model of the expected FIFO contents.
module tb_uart_rx_os;
    localparam int DEPTH = 4;

    logic        clk, resetn, uart_rxd, uart_rx_en, rx_valid, rx_ready, rx_overrun, overrun_clr;
    logic [15:0] baud_div;
    logic [1:0]  parity_mode;
    logic [7:0]  rx_data;
    logic [2:0]  rx_flags;
    logic [2:0]  fifo_level;

    int          checks = 0;
    int          errors = 0;
    int          lat;
    logic [10:0] exp_q[$];
    logic [10:0] e;
    logic        exp_ovr = 1'b0;
    logic        ignore  = 1'b0;

    uart_rx_os #(.PAYLOAD_BITS(8), .STOP_BITS(1), .OVERSAMPLE(16), .FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
        .clk(clk), .resetn(resetn), .uart_rxd(uart_rxd), .uart_rx_en(uart_rx_en),
        .baud_div(baud_div), .parity_mode(parity_mode), .rx_data(rx_data), .rx_flags(rx_flags),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_overrun(rx_overrun),
        .overrun_clr(overrun_clr), .fifo_level(fifo_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected head entry {break, parity_err, frame_err, data} from the frame as sent
    function automatic logic [10:0] model(input logic [7:0] d, input logic [1:0] pm,
                                          input logic pbit, input logic stop);
        int   total;
        logic hp, perr, ferr, brk;
        hp    = (pm == 2'b01) || (pm == 2'b10);
        total = $countones(d) + int'(pbit);
        perr  = hp && ((total % 2) != ((pm == 2'b10) ? 1 : 0));
        ferr  = !stop;
        brk   = (d == 8'h00) && (!hp || !pbit) && ferr;
        return {brk, perr, ferr, d};
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic bad_par,
                              input logic bad_stop, input int abort_bit, input int spike_bit,
                              input logic wobble);
        int          tk, bt;
        logic        hp, pbit;
        logic [15:0] div0;
        logic        bits[$];
        tk   = int'(baud_div) + 1;
        bt   = 16 * tk;
        div0 = baud_div;
        hp   = (pm == 2'b01) || (pm == 2'b10);
        pbit = ((pm == 2'b10) ? ~^d : ^d) ^ bad_par;
        parity_mode = pm;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (hp) bits.push_back(pbit);
        bits.push_back(~bad_stop);
        if (abort_bit < 0) begin
            if (exp_q.size() >= DEPTH) exp_ovr = 1'b1;
            else exp_q.push_back(model(d, pm, hp ? pbit : 1'b0, ~bad_stop));
        end
        for (int i = 0; i < bits.size(); i++) begin
            uart_rxd = bits[i];
            if (wobble && i == 3) baud_div = div0 + 16'd2;
            if (wobble && i == 7) baud_div = div0;
            if (i == abort_bit) begin
                cyc(bt / 2);
                return;
            end
            if (i == spike_bit) begin
                cyc(bt / 2);
                uart_rxd = ~bits[i];
                cyc(tk);
                uart_rxd = bits[i];
                cyc(bt - bt / 2 - tk);
            end else begin
                cyc(bt);
            end
        end
        uart_rxd = 1'b1;
        baud_div = div0;
        cyc(2 * bt);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 4000 && exp_q.size() > 0; i++) @(negedge clk);
        check("drain", exp_q.size(), 0);
    endtask

    // Pops complete on the next rising edge; score the head entry now
    always @(negedge clk) begin
        if (resetn && rx_valid && rx_ready) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rx_data", 32'(rx_data), 32'(e[7:0]));
                check("rx_flags", 32'(rx_flags), 32'(e[10:8]));
            end else if (!ignore) begin
                check("spurious_pop", 32'(rx_valid & rx_ready), 0);
            end
        end
    end

    initial begin
        resetn = 1'b0; uart_rxd = 1'b1; uart_rx_en = 1'b1; baud_div = 16'd3;
        parity_mode = 2'b00; rx_ready = 1'b1; overrun_clr = 1'b0;
        cyc(3);
        check("rst_valid", 32'(rx_valid), 0);
        check("rst_data", 32'(rx_data), 0);
        check("rst_flags", 32'(rx_flags), 0);
        check("rst_overrun", 32'(rx_overrun), 0);
        check("rst_level", 32'(fifo_level), 0);
        resetn = 1'b1;
        cyc(40);

        // basic frame with latency bound of 10 bit-times
        lat = 0;
        fork
            send_frame(8'hA5, 2'b00, 1'b0, 1'b0, -1, -1, 1'b0);
            begin
                while (!rx_valid && lat < 640) begin
                    @(negedge clk);
                    lat++;
                end
                check("latency_in_bound", 32'(rx_valid), 1);
            end
        join
        wait_drain();

        // parity
        send_frame(8'h37, 2'b01, 1'b1, 1'b0, -1, -1, 1'b0);
        send_frame(8'h37, 2'b01, 1'b0, 1'b0, -1, -1, 1'b0);
        send_frame(8'h00, 2'b10, 1'b0, 1'b0, -1, -1, 1'b0);
        wait_drain();

        // break: first entry is all-zero with break and frame error
        parity_mode = 2'b00;
        exp_q.push_back({3'b101, 8'h00});
        ignore   = 1'b1;
        uart_rxd = 1'b0;
        cyc(20 * 64);
        uart_rxd = 1'b1;
        cyc(15 * 64);
        check("break_seen", exp_q.size(), 0);
        ignore = 1'b0;
        exp_q.delete();

        // noise: short glitch gives a false start, then a spiked bit is outvoted
        rx_ready = 1'b0;
        uart_rxd = 1'b0;
        cyc(8);
        uart_rxd = 1'b1;
        cyc(3 * 64);
        check("glitch_level", 32'(fifo_level), 0);
        rx_ready = 1'b1;
        send_frame(8'h5A, 2'b00, 1'b0, 1'b0, -1, 4, 1'b0);
        wait_drain();

        // overrun
        rx_ready = 1'b0;
        for (int k = 1; k <= 5; k++) send_frame(8'(k), 2'b00, 1'b0, 1'b0, -1, -1, 1'b0);
        check("ovr_level", 32'(fifo_level), exp_q.size());
        check("ovr_set", 32'(rx_overrun), 32'(exp_ovr));
        rx_ready = 1'b1;
        wait_drain();
        check("ovr_sticky", 32'(rx_overrun), 32'(exp_ovr));
        overrun_clr = 1'b1;
        cyc(1);
        overrun_clr = 1'b0;
        exp_ovr = 1'b0;
        check("ovr_clr", 32'(rx_overrun), 32'(exp_ovr));

        // asynchronous reset mid-frame with a non-empty FIFO
        rx_ready = 1'b0;
        send_frame(8'h11, 2'b00, 1'b0, 1'b0, -1, -1, 1'b0);
        check("pre_rst_level", 32'(fifo_level), exp_q.size());
        send_frame(8'h99, 2'b00, 1'b0, 1'b0, 5, -1, 1'b0);
        #2 resetn = 1'b0;
        #1;
        exp_q.delete();
        check("arst_valid", 32'(rx_valid), 0);
        check("arst_level", 32'(fifo_level), exp_q.size());
        check("arst_data", 32'(rx_data), 0);
        uart_rxd = 1'b1;
        cyc(3);
        resetn = 1'b1;
        cyc(64);
        rx_ready = 1'b1;
        send_frame(8'h3C, 2'b00, 1'b0, 1'b0, -1, -1, 1'b0);
        wait_drain();

        // disable mid-frame: frame dropped, FIFO retained
        rx_ready = 1'b0;
        send_frame(8'h22, 2'b00, 1'b0, 1'b0, -1, -1, 1'b0);
        send_frame(8'h66, 2'b00, 1'b0, 1'b0, 5, -1, 1'b0);
        uart_rx_en = 1'b0;
        cyc(64);
        uart_rxd = 1'b1;
        cyc(64);
        uart_rx_en = 1'b1;
        cyc(128);
        check("dis_level", 32'(fifo_level), exp_q.size());
        check("dis_head", 32'(rx_data), 32'(exp_q[0][7:0]));
        rx_ready = 1'b1;
        wait_drain();

        // random frames: data, parity mode, parity/stop corruption, baud, mid-frame divisor change
        for (int r = 0; r < 24; r++) begin
            baud_div = 16'($urandom_range(2, 5));
            cyc(4);
            send_frame(($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom),
                       2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 5) == 0, -1, -1, $urandom_range(0, 3) == 0);
        end
        wait_drain();
        check("final_overrun", 32'(rx_overrun), 32'(exp_ovr));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
